// File: rtl/drl_pkg.sv
// Shared constants and state encoding for the datapath blocks downstream of the MAC array.
// Consumed by psum_accumulator; the saturation bounds follow ACC_WIDTH.
package drl_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int COLUMN_NUM       = 6;
    localparam int OUT_WIDTH        = 16;
    localparam int COLUMN_OUT_WIDTH = 19;
    localparam int ACC_WIDTH        = 24;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational signed adder that clamps to the WIDTH-bit signed range.
// o_ovf flags that the clamp was applied this addition.
module sat_add #(
    parameter int WIDTH = 24
) (
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic signed [WIDTH-1:0] o_sum,
    output logic                    o_ovf
);

    logic signed [WIDTH:0] w_wide;

    assign w_wide = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};
    // The extra bit disagrees with the sign bit exactly when the true sum leaves the range.
    assign o_ovf  = w_wide[WIDTH] ^ w_wide[WIDTH-1];

    always_comb begin
        o_sum = w_wide[WIDTH-1:0];
        if (o_ovf) begin
            o_sum = w_wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates groups of signed column psums into saturated output-pixel sums behind a valid/ready port.
// Optional PSUM_ACCUMULATOR_RELU_EN clamps negative group results to zero at the output register.
module psum_accumulator #(
    parameter int COLUMN_OUT_WIDTH = 19,
    parameter int ACC_WIDTH        = 24,
    parameter int LEN_WIDTH        = 8
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_clear,
    input  logic [LEN_WIDTH-1:0]               i_acc_len,
    input  logic                               i_valid,
    input  logic signed [COLUMN_OUT_WIDTH-1:0] i_psum_column,
    output logic                               o_ready,
    output logic                               o_valid,
    output logic signed [ACC_WIDTH-1:0]        o_acc,
    output logic                               o_last_err,
    input  logic                               i_ready
);

    import drl_pkg::*;

    // Handshake: a beat moves on i_valid && o_ready, a result on o_valid && i_ready;
    // o_ready = !o_valid || i_ready, so an unconsumed result stalls every input beat.

    state_t                      r_state;
    state_t                      w_state_next;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] r_out;
    logic [LEN_WIDTH-1:0]        r_cnt;
    logic [LEN_WIDTH-1:0]        r_len_q;
    logic                        r_valid;
    logic                        r_err;

    logic signed [ACC_WIDTH-1:0] w_in_ext;
    logic signed [ACC_WIDTH-1:0] w_base;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic signed [ACC_WIDTH-1:0] w_result;
    logic [LEN_WIDTH-1:0]        w_len_eff;
    logic                        w_ovf;
    logic                        w_accept;
    logic                        w_consume;
    logic                        w_first;
    logic                        w_final;

    assign o_ready    = !r_valid || i_ready;
    assign o_valid    = r_valid;
    assign o_acc      = r_out;
    assign o_last_err = r_err;

    assign w_accept  = i_valid && o_ready && !i_clear;
    assign w_consume = r_valid && i_ready;
    assign w_first   = (r_state == ST_IDLE);
    // The length is taken live only on the first beat; a zero length behaves as one.
    assign w_len_eff = !w_first ? r_len_q :
                       (i_acc_len == '0) ? LEN_WIDTH'(1) : i_acc_len;
    assign w_final   = (r_cnt == w_len_eff - LEN_WIDTH'(1));
    assign w_in_ext  = ACC_WIDTH'(i_psum_column);
    assign w_base    = w_first ? '0 : r_acc;

    sat_add #(
        .WIDTH (ACC_WIDTH)
    ) u_sat_add (
        .i_a   (w_base),
        .i_b   (w_in_ext),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

`ifdef PSUM_ACCUMULATOR_RELU_EN
    assign w_result = w_sum[ACC_WIDTH-1] ? '0 : w_sum;
`else
    assign w_result = w_sum;
`endif

    always_comb begin
        w_state_next = r_state;
        if (i_clear) begin
            w_state_next = ST_IDLE;
        end else if (w_accept) begin
            w_state_next = w_final ? ST_IDLE : ST_ACCUM;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len_q <= LEN_WIDTH'(1);
            r_valid <= 1'b0;
            r_out   <= '0;
            r_err   <= 1'b0;
        end else begin
            // A new result overwrites the one being consumed in the same cycle.
            if (w_accept && w_final) begin
                r_out   <= w_result;
                r_valid <= 1'b1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end

            if (i_clear) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_err <= 1'b0;
            end else if (w_accept) begin
                if (w_ovf) begin
                    r_err <= 1'b1;
                end
                if (w_first) begin
                    r_len_q <= w_len_eff;
                end
                if (w_final) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + LEN_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the MAC column adder tree and consumes its per-cycle signed column partial sum.
- Accumulates a configurable number of column psums (kernel rows × input channels) into one output-pixel sum.
- Registers the result and presents it through a valid/ready handshake to the writeback/activation stage.
- Saturates on overflow, so long accumulations never wrap.

Parameters:
- COLUMN_OUT_WIDTH, 19, width of incoming signed column psum.
- ACC_WIDTH, 24, width of internal accumulator and output; must be ≥ COLUMN_OUT_WIDTH.
- LEN_WIDTH, 8, width of the accumulation-length config and the counter.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_clear  input  1  synchronous abort; drops any partial group.
- i_acc_len  input  LEN_WIDTH  number of psums per group; sampled on the first beat of each group.
- i_valid  input  1  i_psum_column is valid.
- i_psum_column  input  signed COLUMN_OUT_WIDTH  column partial sum.
- o_ready  output  1  block accepts a beat this cycle.
- o_valid  output  1  o_acc holds a completed group.
- o_acc  output  signed ACC_WIDTH  accumulated (saturated) group sum.
- o_last_err  output  1  sticky flag: saturation occurred in any group since reset/clear.
- i_ready  input  1  downstream accepts o_acc.

Behaviour:
- Reset (async, i_rst=1): acc=0, cnt=0, len_q=1, o_valid=0, o_acc=0, o_last_err=0. State is IDLE.
- Handshake:
  - Beat accepted when i_valid && o_ready.
  - Result consumed when o_valid && i_ready.
  - o_ready = !o_valid || i_ready (combinational). While a result is held and not consumed, all input stalls, including non-final beats.
- States:
  - IDLE (cnt==0, no partial sum).
  - ACCUM (0<cnt<len_q).
  - A completed result lives only in the output register; o_valid is tracked separately from the state.
- First beat (cnt==0):
  - len_q = (i_acc_len==0) ? 1 : i_acc_len.
  - acc = sext(in).
- Later beats: acc = sat(acc + sext(in)).
- Sign extension and saturation:
  - Addition uses ACC_WIDTH+1 bits.
  - Results above 2^(ACC_WIDTH-1)-1 or below -2^(ACC_WIDTH-1) clamp to the bound and set o_last_err.
- Final beat (cnt==len_q-1, including len_q==1 on the first beat):
  - o_acc <= sat(acc_next); o_valid <= 1.
  - acc <= 0; cnt <= 0; return to IDLE.
  - Latency: o_valid asserts on the cycle after the final beat is accepted.
- Otherwise cnt <= cnt+1 and state is ACCUM.
- Simultaneous final beat and output consumption (o_valid && i_ready && final accept): the new result replaces the old one and o_valid stays 1. This allows one group per len_q cycles with no bubble.
- Output consumed with no new final beat: o_valid <= 0. o_acc keeps its last value.
- i_clear=1:
  - acc=0, cnt=0, state IDLE, o_last_err=0.
  - Any input beat that cycle is ignored.
  - o_valid and o_acc are unaffected, so a completed result is still delivered.
  - i_clear has priority over the beat.
- i_acc_len changes mid-group have no effect until the next group.
- Async reset mid-group discards everything immediately.

Optional Feature:
- PSUM_ACCUMULATOR_RELU_EN.
  - Defined: the value registered into o_acc is max(sat(acc_next), 0), so negative groups output 0. o_last_err is still set by saturation before the ReLU.
  - Undefined: o_acc is the signed saturated sum. No ReLU logic is synthesized.

Decomposition:
- Shared package (drl_pkg):
  - Constants DATA_WIDTH=8, COLUMN_NUM=6, OUT_WIDTH=16, COLUMN_OUT_WIDTH=19, ACC_WIDTH=24.
  - State encoding localparams ST_IDLE/ST_ACCUM.
  - Saturation bound constants ACC_MAX/ACC_MIN.
- One natural sub-module, sat_add: a combinational signed adder with saturate plus overflow flag, parameterised by width. Reused later by the pooling stage.
- Counter, length latch and output register stay in the top.

Test Plan:
- Basic group:
  - Stimulus: i_acc_len=3, i_ready=1; beats 100, -20, 5 on consecutive cycles.
  - Response: one cycle after the third beat, o_valid=1 and o_acc=85. Next cycle o_valid=0 (no new group).
- Length 0/1:
  - Stimulus: i_acc_len=0, beats 7 then -9.
  - Response: two results, 7 and -9, each the cycle after its beat.
- Saturation:
  - Stimulus: i_acc_len=64, all beats +262143.
  - Response: o_acc=8388607, o_last_err=1.
  - Repeat with -262144 beats: o_acc=-8388608.
- Backpressure:
  - Stimulus: i_acc_len=2, i_ready=0 after the first result; keep driving beats.
  - Response: o_ready=0, o_acc held, no beats lost. Raising i_ready resumes, and the second group sums correctly.
- Back-to-back with consume:
  - Stimulus: i_acc_len=1, i_ready=1, beats 1,2,3,4 on consecutive cycles.
  - Response: o_valid stays 1 for 4 cycles with o_acc=1,2,3,4, and o_ready stays 1.
- Clear and reset mid-group:
  - Stimulus: i_acc_len=4, beats 10,10, then i_clear, then beats 1,1,1,1.
  - Response: result 4.
  - Then assert i_rst mid-group: o_valid, o_acc and o_last_err go to 0 immediately.
  - With PSUM_ACCUMULATOR_RELU_EN defined, beats -5,-5 at len 2 give o_acc=0.
